// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// =====================================================================
// Module   : mips_multicycle_ctrl_if
// Brief    : Controller <-> datapath bundle (opcode, flags, strobes).
// Revision : 1.0
// =====================================================================
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;

  // Zero is consumed by the datapath's PC-enable logic, not the sequencer
  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );

  modport slave (
    output opcode, Zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// =====================================================================
// Module   : mips_multicycle_ctrl
// Brief    : Moore sequencer for the multi-cycle MIPS datapath.
//            Define MIPS_CTRL_JUMP_EN to enable the j instruction.
// Revision : 1.0
// =====================================================================
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                   CLK,
  input  logic                   RESET,
  mips_multicycle_ctrl_if.master bus,
  output logic [3:0]             state,
  output logic                   retire,
  output logic                   illegal,
  output logic [CNT_W-1:0]       instr_count
);

  localparam logic [5:0] c_OP_RTYPE = 6'd0;
  localparam logic [5:0] c_OP_J     = 6'd2;
  localparam logic [5:0] c_OP_BEQ   = 6'd4;
  localparam logic [5:0] c_OP_ADDI  = 6'd8;
  localparam logic [5:0] c_OP_LW    = 6'd35;
  localparam logic [5:0] c_OP_SW    = 6'd43;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IEXEC  = 4'd11,
    S_IWB    = 4'd12
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_run;
  logic             r_is_store;
  logic [CNT_W-1:0] r_count;

  // r_run holds IDLE for one full cycle after reset release
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_run      <= 1'b0;
      r_is_store <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
      if (r_state == S_DECODE) begin
        r_is_store <= (bus.opcode == c_OP_SW);
      end
      if (retire) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next          = S_IDLE;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    retire          = 1'b0;
    illegal         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_next = r_run ? S_FETCH : S_IDLE;
      end
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        w_next      = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        case (bus.opcode)
          c_OP_RTYPE:      w_next = S_EXEC;
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_BEQ:        w_next = S_BRANCH;
          c_OP_ADDI:       w_next = S_IEXEC;
`ifdef MIPS_CTRL_JUMP_EN
          c_OP_J:          w_next = S_JUMP;
`endif
          default: begin
            illegal = 1'b1;
            w_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        w_next      = r_is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        w_next      = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        retire       = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        retire       = bus.mem_ready;
        w_next       = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        w_next      = S_RWB;
      end
      S_RWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        retire       = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        retire          = 1'b1;
        w_next          = S_FETCH;
      end
      S_IEXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        w_next      = S_IWB;
      end
      S_IWB: begin
        bus.RegWrite = 1'b1;
        retire       = 1'b1;
        w_next       = S_FETCH;
      end
`ifdef MIPS_CTRL_JUMP_EN
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        retire       = 1'b1;
        w_next       = S_FETCH;
      end
`endif
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign state       = r_state;
  assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// Directed, table-driven bench for mips_multicycle_ctrl (CNT_W=3 to reach wrap).
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 3;

  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3,
                         MEMRD = 4'd4, MEMWB = 4'd5, MEMWR = 4'd6, EXEC = 4'd7,
                         RWB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, IEXEC = 4'd11,
                         IWB = 4'd12;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
  //  ALUSrcA,ALUSrcB[2],ALUOp[2],PCSource[2],retire,illegal}
  localparam logic [17:0] O_IDLE     = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_FETCH_R  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] O_FETCH_W  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] O_DECODE   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] O_DEC_ILL  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [17:0] O_MEMADR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] O_MEMRD    = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_MEMWB    = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] O_MEMWR_W  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] O_MEMWR_R  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] O_EXEC     = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] O_RWB      = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] O_BRANCH   = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] O_IEXEC    = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] O_IWB      = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
`ifdef MIPS_CTRL_JUMP_EN
  localparam logic [17:0] O_JUMP     = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
`endif

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] out;
    int          cnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       state;
  logic             retire;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;
  logic [17:0]      outs;
  int               n_cmp = 0;
  int               n_bad = 0;
  vec_t             tbl[$];

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK         (clk),
    .RESET       (rst),
    .bus         (bus),
    .state       (state),
    .retire      (retire),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  assign outs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                 bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                 bus.ALUSrcB, bus.ALUOp, bus.PCSource, retire, illegal};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                     input logic [17:0] out, input int cnt);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.out = out; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus.opcode = 6'd0; bus.mem_ready = 1'b0; bus.Zero = 1'b0;

    // R-type, starting from the cycle after the first edge past release
    add(6'd0, 1, IDLE, O_IDLE, 0);     add(6'd0, 1, FETCH, O_FETCH_R, 0);
    add(6'd0, 1, DECODE, O_DECODE, 0); add(6'd0, 1, EXEC, O_EXEC, 0);
    add(6'd0, 1, RWB, O_RWB, 0);
    // lw with two MEMRD waits
    add(6'd35, 1, FETCH, O_FETCH_R, 1); add(6'd35, 1, DECODE, O_DECODE, 1);
    add(6'd35, 1, MEMADR, O_MEMADR, 1); add(6'd35, 0, MEMRD, O_MEMRD, 1);
    add(6'd35, 0, MEMRD, O_MEMRD, 1);   add(6'd35, 1, MEMRD, O_MEMRD, 1);
    add(6'd35, 1, MEMWB, O_MEMWB, 1);
    // sw with three FETCH waits and one MEMWR wait
    add(6'd43, 0, FETCH, O_FETCH_W, 2); add(6'd43, 0, FETCH, O_FETCH_W, 2);
    add(6'd43, 0, FETCH, O_FETCH_W, 2); add(6'd43, 1, FETCH, O_FETCH_R, 2);
    add(6'd43, 1, DECODE, O_DECODE, 2); add(6'd43, 1, MEMADR, O_MEMADR, 2);
    add(6'd43, 0, MEMWR, O_MEMWR_W, 2); add(6'd43, 1, MEMWR, O_MEMWR_R, 2);
    // beq (mem_ready ignored in BRANCH), addi
    add(6'd4, 1, FETCH, O_FETCH_R, 3);  add(6'd4, 1, DECODE, O_DECODE, 3);
    add(6'd4, 0, BRANCH, O_BRANCH, 3);
    add(6'd8, 1, FETCH, O_FETCH_R, 4);  add(6'd8, 1, DECODE, O_DECODE, 4);
    add(6'd8, 0, IEXEC, O_IEXEC, 4);    add(6'd8, 1, IWB, O_IWB, 4);
    // illegal opcode 63, then opcode 2
    add(6'd63, 1, FETCH, O_FETCH_R, 5); add(6'd63, 1, DECODE, O_DEC_ILL, 5);
    add(6'd2, 1, FETCH, O_FETCH_R, 5);
`ifdef MIPS_CTRL_JUMP_EN
    add(6'd2, 1, DECODE, O_DECODE, 5);  add(6'd2, 1, JUMP, O_JUMP, 5);
`else
    add(6'd2, 1, DECODE, O_DEC_ILL, 5);
    add(6'd0, 1, FETCH, O_FETCH_R, 5);  add(6'd0, 1, DECODE, O_DECODE, 5);
    add(6'd0, 1, EXEC, O_EXEC, 5);      add(6'd0, 1, RWB, O_RWB, 5);
`endif
    // two beqs take the 3-bit counter through 7 and wrap to 0
    add(6'd4, 1, FETCH, O_FETCH_R, 6);  add(6'd4, 1, DECODE, O_DECODE, 6);
    add(6'd4, 1, BRANCH, O_BRANCH, 6);
    add(6'd4, 1, FETCH, O_FETCH_R, 7);  add(6'd4, 1, DECODE, O_DECODE, 7);
    add(6'd4, 1, BRANCH, O_BRANCH, 7);
    add(6'd43, 1, FETCH, O_FETCH_R, 0);

    // outputs held at zero during reset even with live inputs
    repeat (2) @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    #1;
    chk("reset state", 32'(state), 32'(IDLE));
    chk("reset outs", 32'(outs), 32'(O_IDLE));
    chk("reset count", 32'(instr_count), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release state", 32'(state), 32'(IDLE));
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      bus.opcode    = tbl[i].op;
      bus.mem_ready = tbl[i].mr;
      #1;
      chk($sformatf("row%0d state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("row%0d outs", i), 32'(outs), 32'(tbl[i].out));
      chk($sformatf("row%0d count", i), 32'(instr_count), 32'(tbl[i].cnt));
      @(posedge clk);
      #1;
    end

    // reset asserted while a store waits in MEMWR
    #1;
    chk("abort decode", 32'(state), 32'(DECODE));
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    chk("abort memadr", 32'(state), 32'(MEMADR));
    @(posedge clk);
    #1;
    chk("abort memwr", 32'(state), 32'(MEMWR));
    chk("abort memwrite on", 32'(bus.MemWrite), 1);
    rst = 1'b1;
    #1;
    chk("abort memwrite off", 32'(bus.MemWrite), 0);
    chk("abort outs", 32'(outs), 32'(O_IDLE));
    chk("abort state", 32'(state), 32'(IDLE));
    chk("abort count", 32'(instr_count), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("resume idle", 32'(state), 32'(IDLE));
    @(posedge clk);
    #1;
    chk("resume fetch", 32'(state), 32'(FETCH));
    repeat (3) @(posedge clk);
    #1;
    chk("resume rwb", 32'(state), 32'(RWB));
    @(posedge clk);
    #1;
    chk("resume fetch2", 32'(state), 32'(FETCH));
    chk("resume count", 32'(instr_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle sequencer for the MIPS datapath: a Moore state machine that steps each instruction through fetch, decode, execute, memory and write-back, driving PC write, IR load, register-file write, ALU operand selects and ALUOp. It sits between the instruction register's opcode field and the existing PC, instruction memory, register file, ALUControl and MIPSALU blocks, replacing the single-cycle CONTROL decoder. It adds a memory-ready handshake, illegal-opcode detection and a retired-instruction counter.

## Interface
- CNT_W, 32: width of the retired-instruction counter.
- CLK  in  1  system clock, rising edge active.
- RESET  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath strobes and selects.
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUOp  out  2  00 = add, 01 = subtract, 10 = use funct.
- PCSource  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- state  out  4  current state, for debug.
- retire  out  1  one-cycle pulse on the final cycle of each completed instruction.
- illegal  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- instr_count  out  CNT_W  number of retired instructions.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, IEXEC=11, IWB=12. Codes 13–15 are unused and go to IDLE.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target). Dispatch on opcode:
  - 0 → EXEC
  - 35 (lw) and 43 (sw) → MEMADR
  - 4 (beq) → BRANCH
  - 8 (addi) → IEXEC
  - 2 (j) → JUMP
  - anything else → illegal=1 for this cycle, then FETCH. The instruction is not retired.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Stay until mem_ready=1, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, retire=1. Next is FETCH.
- MEMWR: MemWrite=1, IorD=1. Stay until mem_ready=1. On that cycle retire=1 and next is FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0, retire=1. Next is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, retire=1. Next is FETCH. The datapath writes PC when Zero=1.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0, retire=1. Next is FETCH.
- JUMP: PCWrite=1, PCSource=10, retire=1. Next is FETCH.
- Any output not listed for a state is 0 in that state.
- instr_count increments by 1 on each rising edge where retire=1. It wraps from 2^CNT_W−1 to 0 with no flag.

## Timing
- state and instr_count are registered; all other outputs are combinational decodes of state, plus mem_ready where stated above. Opcode is sampled only in DECODE.
- Reset: RESET asynchronously forces state=IDLE and instr_count=0. All outputs are 0 while RESET=1 and in the first cycle after it is released. FETCH begins on the second rising edge after release.
- Reset asserted mid-instruction aborts it immediately. No write strobe is asserted after RESET rises, and the aborted instruction is not counted.
- Cycles per instruction with mem_ready tied to 1:
  - R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
  - Each wait cycle (mem_ready=0 in FETCH, MEMRD or MEMWR) adds one cycle.
- mem_ready is ignored in every other state.
- retire and an instr_count rollover in the same cycle are legal. The count becomes 0.

## Configuration
- MIPS_CTRL_JUMP_EN:
  - Defined: opcode 2 dispatches to JUMP as described.
  - Undefined: the JUMP state and PCSource=10 are never produced, and opcode 2 is illegal (illegal pulse in DECODE, then FETCH, not retired).

## Test plan
- RESET pulse, then mem_ready=1 and opcode=0 held: state sequence IDLE, FETCH, DECODE, EXEC, RWB, FETCH. RegWrite=1 and RegDst=1 only in RWB. instr_count=1 after RWB.
- lw (opcode 35) with mem_ready=0 for 2 cycles in MEMRD: 7 cycles from FETCH to FETCH. RegWrite and MemtoReg are 1 only in MEMWB.
- sw (opcode 43) with mem_ready low for 3 cycles in FETCH: IRWrite and PCWrite stay 0 until mem_ready=1. MemWrite=1 in MEMWR. retire pulses once.
- beq (opcode 4): BRANCH asserts PCWriteCond=1, PCSource=01, ALUOp=01. Takes 3 cycles. instr_count increments.
- opcode 63: illegal=1 for exactly one cycle in DECODE, then FETCH. instr_count unchanged. Repeat with opcode 2 and the macro undefined: same response.
- RESET asserted in MEMWR while mem_ready=0: MemWrite drops to 0 immediately, state=IDLE, instr_count=0. Operation resumes normally after release.
